core_psum_acc: RTL and testbench
================================

Name: core_psum_acc

Overview:
- Partial-sum accumulator that sits directly upstream of the recompute (scale/shift/round/saturate) stage.
- Sums a programmable number of signed partial sums per output element, saturating at each add.
- Emits one result per group on an out_data/out_data_vld pair that connects directly to the recompute stage's in_data/in_data_vld.
- Also reports per-result saturation and a sticky protocol error.

Parameters:
IN_DATA_WIDTH, 16, width of signed incoming partial sum
OUT_DATA_WIDTH, 24, width of signed accumulated result (equals recompute stage IN_DATA_WIDTH)
ACC_CNT_WIDTH, 8, width of group-length config and internal term counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
acc_len  input  ACC_CNT_WIDTH  terms per group, unsigned, legal range 1..2^ACC_CNT_WIDTH-1
acc_len_vld  input  1  one-cycle strobe latching acc_len
acc_clear  input  1  abort/deconfigure strobe
in_psum  input  IN_DATA_WIDTH  signed partial sum
in_psum_vld  input  1  in_psum valid; no backpressure, every valid beat is consumed
out_data  output  OUT_DATA_WIDTH  signed accumulated result
out_data_vld  output  1  one-cycle pulse per completed group
out_sat  output  1  high with out_data_vld if any add in that group saturated
busy  output  1  partial group in progress (term counter != 0)
error  output  1  sticky protocol error

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: out_data=0, out_data_vld=0, out_sat=0, busy=0, error=0, state=UNCFG, counter=0, accumulator=0, latched length=0.
- All outputs are registered.
- States:
  - UNCFG: no valid length latched.
  - ACC: length latched, accepting beats.
- Transitions and events in UNCFG:
  - acc_len_vld with acc_len!=0: latch length, counter=0, go to ACC.
  - acc_len_vld with acc_len==0: set error, stay in UNCFG.
  - in_psum_vld: beat dropped, set error, no output.
- Beats in ACC:
  - Operand is sign-extended in_psum.
  - counter==0 (first term): acc <= operand; group saturation flag <= 0.
  - Otherwise: acc <= sat(acc + operand). The sum is computed at OUT_DATA_WIDTH+1 bits and clamped to [-2^(OUT-1), 2^(OUT-1)-1]. Any clamp sets the group saturation flag.
  - Beat with counter==len-1 (last term):
    - out_data <= the final sum (same saturation rule); out_sat <= group flag OR this beat's clamp; out_data_vld <= 1 on the next cycle.
    - counter <= 0. Latency is exactly 1 cycle after the last beat.
  - Otherwise counter increments. out_data holds its value between pulses.
- Length 1: every beat produces an output one cycle later, with out_sat=0.
- Back-to-back groups: no bubble required. A new group's first beat may arrive the cycle after the previous group's last beat.
- acc_len_vld while in ACC:
  - counter==0: new length latched and applies to the beat in the same cycle, if any. acc_len==0 sets error and the old length is kept.
  - counter!=0: ignored, sets error.
- acc_clear (highest priority):
  - Next state is UNCFG; counter=0, acc=0, partial group discarded, error cleared.
  - No out_data_vld is produced for the discarded group; out_data_vld is 0 on the next cycle.
  - acc_len_vld or in_psum_vld in the same cycle is ignored and does not set error.
- Reset mid-group: all state returns immediately to reset values; no output is generated.
- busy = (state==ACC && counter!=0), registered.
- error stays set until acc_clear or rst.

Test Plan:
1. Default params: acc_len=4 strobe, beats 1,2,3,4 consecutive -> single out_data_vld one cycle after beat 4, out_data=10, out_sat=0; busy high after beat 1 until after beat 4.
2. acc_len=1, beats 5,-7,0 back-to-back -> three pulses in consecutive cycles with out_data 5,-7,0; busy stays 0.
3. OUT_DATA_WIDTH=18, acc_len=8:
   - Eight beats of 32767 -> out_data=131071, out_sat=1.
   - Then eight beats of -32768 -> out_data=-131072, out_sat=1.
   - Then 8 beats of 1 -> out_data=8, out_sat=0.
4. Config errors:
   - in_psum_vld=1 before any config -> error=1, no out_data_vld.
   - acc_len_vld with acc_len=0 -> error stays 1.
   - acc_clear -> error=0.
   - acc_len_vld with acc_len=3 after 1 of 4 beats -> error=1 and the group still completes after 4 beats.
5. acc_len=4, beats 1,2 then acc_clear -> no pulse, state UNCFG. Subsequent beats set error until reconfigured. Reconfigure len=2, beats 3,4 -> out_data=7.
6. acc_len=4, two beats, then rst pulsed asynchronously mid-cycle -> all outputs 0 immediately. Beats after release set error until reconfigured.
7. Chain with the recompute stage (rc_scale=0x0abc, rc_shift=10): random groups of acc_len=4 -> out_data matches the software model (sum, then scale/shift/round/saturate).

Source files
------------

// File: rtl/core_psum_acc.sv
// Partial-sum accumulator feeding the recompute stage: sums acc_len signed
// partial sums per group with per-add saturation and emits one registered result per group.
module core_psum_acc #(
   parameter int IN_DATA_WIDTH  = 16,
   parameter int OUT_DATA_WIDTH = 24,
   parameter int ACC_CNT_WIDTH  = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [ACC_CNT_WIDTH-1:0]         acc_len,
   input  logic                             acc_len_vld,
   input  logic                             acc_clear,
   input  logic signed [IN_DATA_WIDTH-1:0]  in_psum,
   input  logic                             in_psum_vld,
   output logic signed [OUT_DATA_WIDTH-1:0] out_data,
   output logic                             out_data_vld,
   output logic                             out_sat,
   output logic                             busy,
   output logic                             error
);

   localparam int OW = OUT_DATA_WIDTH;
   localparam int IW = IN_DATA_WIDTH;
   localparam int CW = ACC_CNT_WIDTH;

   typedef enum logic {UNCFG = 1'b0, ACC = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         len_q, len_d, len_eff;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic signed [OW-1:0]  acc_q, acc_d;
   logic                  gsat_q, gsat_d;
   logic signed [OW-1:0]  out_data_q, out_data_d;
   logic                  out_vld_q, out_vld_d;
   logic                  out_sat_q, out_sat_d;
   logic                  busy_q, busy_d;
   logic                  error_q, error_d;

   logic signed [OW-1:0]  operand;
   logic signed [OW:0]    sum_wide;
   logic signed [OW-1:0]  sat_val, res;
   logic                  clamp, first, last, gsat_next;

   // Next-state computation: clear has priority, then config strobe, then beat.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      gsat_d     = gsat_q;
      out_data_d = out_data_q;
      out_vld_d  = 1'b0;
      out_sat_d  = out_sat_q;
      error_d    = error_q;
      len_eff    = len_q;

      operand  = {{(OW-IW){in_psum[IW-1]}}, in_psum};
      sum_wide = {acc_q[OW-1], acc_q} + {operand[OW-1], operand};
      clamp    = 1'b0;
      if (sum_wide[OW] != sum_wide[OW-1]) begin
         clamp   = 1'b1;
         sat_val = sum_wide[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
      end else begin
         sat_val = sum_wide[OW-1:0];
      end

      first     = (cnt_q == {CW{1'b0}});
      res       = first ? operand : sat_val;
      gsat_next = first ? 1'b0 : (gsat_q | clamp);
      last      = 1'b0;

      if (acc_clear) begin
         state_d = UNCFG;
         len_d   = {CW{1'b0}};
         cnt_d   = {CW{1'b0}};
         acc_d   = {OW{1'b0}};
         gsat_d  = 1'b0;
         error_d = 1'b0;
      end else begin
         if (acc_len_vld) begin
            if (acc_len == {CW{1'b0}}) begin
               error_d = 1'b1;
            end else if (state_q == UNCFG) begin
               state_d = ACC;
               len_d   = acc_len;
               cnt_d   = {CW{1'b0}};
            end else if (first) begin
               len_d   = acc_len;
               len_eff = acc_len;
            end else begin
               error_d = 1'b1;
            end
         end else begin
            len_eff = len_q;
         end

         if (in_psum_vld) begin
            if (state_q == UNCFG) begin
               error_d = 1'b1;
            end else begin
               last  = (cnt_q == (len_eff - {{(CW-1){1'b0}}, 1'b1}));
               acc_d = res;
               if (last) begin
                  out_data_d = res;
                  out_sat_d  = gsat_next;
                  out_vld_d  = 1'b1;
                  cnt_d      = {CW{1'b0}};
                  gsat_d     = 1'b0;
               end else begin
                  cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                  gsat_d = gsat_next;
               end
            end
         end else begin
            last = 1'b0;
         end
      end

      busy_d = (state_d == ACC) && (cnt_d != {CW{1'b0}});
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= UNCFG;
         len_q      <= {CW{1'b0}};
         cnt_q      <= {CW{1'b0}};
         acc_q      <= {OW{1'b0}};
         gsat_q     <= 1'b0;
         out_data_q <= {OW{1'b0}};
         out_vld_q  <= 1'b0;
         out_sat_q  <= 1'b0;
         busy_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         gsat_q     <= gsat_d;
         out_data_q <= out_data_d;
         out_vld_q  <= out_vld_d;
         out_sat_q  <= out_sat_d;
         busy_q     <= busy_d;
         error_q    <= error_d;
      end
   end

   assign out_data     = out_data_q;
   assign out_data_vld = out_vld_q;
   assign out_sat      = out_sat_q;
   assign busy         = busy_q;
   assign error        = error_q;

endmodule

// File: tb/tb_core_psum_acc.sv
// Bench for core_psum_acc: a default-width and an 18-bit instance share stimulus and
// are checked every cycle against a queue-based group model.
module tb_core_psum_acc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  acc_len = 8'd0;
   logic        acc_len_vld = 1'b0;
   logic        acc_clear = 1'b0;
   logic [15:0] in_psum = 16'd0;
   logic        in_psum_vld = 1'b0;

   logic signed [23:0] od0;
   logic signed [17:0] od1;
   logic vld0, vld1, sat0, sat1, busy0, busy1, err0, err1;

   int n_cmp = 0;
   int n_err = 0;

   // model state: grouping is width independent, only the fold differs
   bit      m_cfg;
   int      m_len;
   longint  m_q[$];
   bit      m_err;
   bit      e_vld;
   longint  e_data[2];
   bit      e_sat[2];

   always #5 clk = ~clk;

   core_psum_acc #(.IN_DATA_WIDTH(16), .OUT_DATA_WIDTH(24), .ACC_CNT_WIDTH(8)) u_dut0 (
      .clk(clk), .rst(rst), .acc_len(acc_len), .acc_len_vld(acc_len_vld),
      .acc_clear(acc_clear), .in_psum(in_psum), .in_psum_vld(in_psum_vld),
      .out_data(od0), .out_data_vld(vld0), .out_sat(sat0), .busy(busy0), .error(err0));

   core_psum_acc #(.IN_DATA_WIDTH(16), .OUT_DATA_WIDTH(18), .ACC_CNT_WIDTH(8)) u_dut1 (
      .clk(clk), .rst(rst), .acc_len(acc_len), .acc_len_vld(acc_len_vld),
      .acc_clear(acc_clear), .in_psum(in_psum), .in_psum_vld(in_psum_vld),
      .out_data(od1), .out_data_vld(vld1), .out_sat(sat1), .busy(busy1), .error(err1));

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void fold(input int w, output longint s, output bit sat);
      longint mx, mn;
      mx  = (64'sd1 <<< (w - 1)) - 1;
      mn  = -(64'sd1 <<< (w - 1));
      s   = m_q[0];
      sat = 1'b0;
      for (int i = 1; i < m_q.size(); i++) begin
         s = s + m_q[i];
         if (s > mx) begin s = mx; sat = 1'b1; end
         if (s < mn) begin s = mn; sat = 1'b1; end
      end
   endfunction

   task automatic model_step(input bit lv, input int l, input bit clr, input bit v, input int p);
      bit was_cfg;
      e_vld = 1'b0;
      if (clr) begin
         m_cfg = 1'b0;
         m_q.delete();
         m_err = 1'b0;
      end else begin
         was_cfg = m_cfg;
         if (lv) begin
            if (l == 0) m_err = 1'b1;
            else if (!m_cfg) begin m_cfg = 1'b1; m_len = l; end
            else if (m_q.size() == 0) m_len = l;
            else m_err = 1'b1;
         end
         if (v) begin
            if (!was_cfg) m_err = 1'b1;
            else begin
               m_q.push_back(longint'(p));
               if (m_q.size() == m_len) begin
                  fold(24, e_data[0], e_sat[0]);
                  fold(18, e_data[1], e_sat[1]);
                  e_vld = 1'b1;
                  m_q.delete();
               end
            end
         end
      end
   endtask

   task automatic check_all();
      bit eb;
      eb = m_cfg && (m_q.size() != 0);
      check("vld0", vld0, e_vld);
      check("vld1", vld1, e_vld);
      check("busy0", busy0, eb);
      check("busy1", busy1, eb);
      check("err0", err0, m_err);
      check("err1", err1, m_err);
      check("data0", od0, e_data[0]);
      check("data1", od1, e_data[1]);
      if (e_vld) begin
         check("sat0", sat0, e_sat[0]);
         check("sat1", sat1, e_sat[1]);
      end
   endtask

   task automatic cycle(input bit lv, input int l, input bit clr, input bit v, input int p);
      @(negedge clk);
      acc_len_vld = lv;
      acc_len     = l[7:0];
      acc_clear   = clr;
      in_psum_vld = v;
      in_psum     = p[15:0];
      @(posedge clk);
      model_step(lv, l, clr, v, p);
      #1;
      check_all();
   endtask

   task automatic beat(input int p);
      cycle(1'b0, 0, 1'b0, 1'b1, p);
   endtask

   task automatic idle();
      cycle(1'b0, 0, 1'b0, 1'b0, 0);
   endtask

   // reset asserted mid-cycle; outputs must drop without waiting for an edge
   task automatic async_reset();
      @(posedge clk);
      #3;
      acc_len_vld = 1'b0;
      acc_clear   = 1'b0;
      in_psum_vld = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_data0", od0, 0);
      check("rst_data1", od1, 0);
      check("rst_vld", vld0 | vld1, 0);
      check("rst_sat", sat0 | sat1, 0);
      check("rst_busy", busy0 | busy1, 0);
      check("rst_err", err0 | err1, 0);
      m_cfg = 1'b0;
      m_q.delete();
      m_err = 1'b0;
      e_vld = 1'b0;
      e_data[0] = 0;
      e_data[1] = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int r, p;
      m_cfg = 1'b0; m_len = 0; m_err = 1'b0; e_vld = 1'b0;
      e_data[0] = 0; e_data[1] = 0; e_sat[0] = 1'b0; e_sat[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // group of four
      cycle(1'b1, 4, 1'b0, 1'b0, 0);
      beat(1); beat(2); beat(3); beat(4);
      check("t1_data", od0, 10);
      idle();

      // length one, back to back
      cycle(1'b1, 1, 1'b0, 1'b0, 0);
      beat(5); check("t2_a", od0, 5);
      beat(-7); check("t2_b", od0, -7);
      beat(0); check("t2_c", od0, 0);
      idle();

      // saturation on the narrow instance
      cycle(1'b1, 8, 1'b0, 1'b0, 0);
      repeat (8) beat(32767);
      check("t3_pos", od1, 131071); check("t3_pos_sat", sat1, 1);
      repeat (8) beat(-32768);
      check("t3_neg", od1, -131072); check("t3_neg_sat", sat1, 1);
      repeat (8) beat(1);
      check("t3_one", od1, 8); check("t3_one_sat", sat1, 0);

      // config errors
      cycle(1'b0, 0, 1'b1, 1'b0, 0);
      beat(9);
      cycle(1'b1, 0, 1'b0, 1'b0, 0);
      cycle(1'b0, 0, 1'b1, 1'b0, 0);
      check("t4_clr", err0, 0);
      cycle(1'b1, 4, 1'b0, 1'b0, 0);
      beat(1);
      cycle(1'b1, 3, 1'b0, 1'b1, 2);
      beat(3); beat(4);
      check("t4_data", od0, 10);

      // clear mid-group, then reconfigure
      cycle(1'b0, 0, 1'b1, 1'b0, 0);
      cycle(1'b1, 4, 1'b0, 1'b0, 0);
      beat(1); beat(2);
      cycle(1'b1, 2, 1'b1, 1'b1, 5);
      beat(6);
      cycle(1'b1, 2, 1'b0, 1'b0, 0);
      beat(3); beat(4);
      check("t5_data", od0, 7);

      // async reset mid-group
      cycle(1'b1, 4, 1'b0, 1'b0, 0);
      beat(11); beat(12);
      async_reset();
      beat(13);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         case ($urandom_range(0, 3))
            0:       p = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
            default: p = int'($signed(16'($urandom())));
         endcase
         if (r < 2)       cycle(1'b0, 0, 1'b1, ($urandom_range(0, 1) != 0), p);
         else if (r < 3)  async_reset();
         else if (r < 10) cycle(1'b1, (($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 9)),
                                1'b0, ($urandom_range(0, 1) != 0), p);
         else if (r < 80) beat(p);
         else             idle();
         if (!m_cfg && $urandom_range(0, 3) == 0)
            cycle(1'b1, $urandom_range(1, 9), 1'b0, 1'b0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
